// File: rtl/scan_ctrl_pkg.sv
// Shared constants for the scan-chain controller: default chain length and FSM state codes.
package scan_ctrl_pkg;

  localparam int CHAIN_LEN_DEFAULT = 8;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_SHIFT_IN  = 3'd1;
  localparam logic [2:0] ST_CAPTURE   = 3'd2;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

endpackage

// File: rtl/scan_bit_counter.sv
// Bit counter for the shift phases: clears on request, counts when enabled,
// flags the last bit position of the chain.
module scan_bit_counter #(
  parameter int CHAIN_LEN = 8,
  parameter int CNT_W     = $clog2(CHAIN_LEN)
) (
  input  logic             clk,
  input  logic             r,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state always uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (r || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == CNT_W'(CHAIN_LEN - 1));

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan-chain sequencer: shifts a pattern in LSB first, pulses a functional
// capture, shifts the response out into result, then signals done.
module scan_chain_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEFAULT
) (
  input  logic                 clk,
  input  logic                 r,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CHAIN_LEN-1:0] pattern,
  input  logic                 scan_out,
  output logic                 scan_en,
  output logic                 scan_in,
  output logic                 capture,
  output logic                 busy,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] result
);

  localparam int CNT_W = $clog2(CHAIN_LEN);

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic [CNT_W-1:0]     w_count;
  logic                 w_tc;
  logic                 w_state_change;
  logic                 w_cnt_en;
  logic [CHAIN_LEN-1:0] w_captured;

  logic [CHAIN_LEN-1:0] r_pattern;
  logic [CHAIN_LEN-1:0] r_shift_out;
  logic [CHAIN_LEN-1:0] r_result;
  logic                 r_scan_en;
  logic                 r_scan_in;
  logic                 r_capture;
  logic                 r_busy;
  logic                 r_done;

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:      if (start)   w_next = ST_SHIFT_IN;
      ST_SHIFT_IN:  if (w_tc)    w_next = ST_CAPTURE;
      ST_CAPTURE:                w_next = ST_SHIFT_OUT;
      ST_SHIFT_OUT: if (w_tc)    w_next = ST_DONE;
      ST_DONE:                   w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
    // abort wins everywhere, including over start in IDLE
    if (abort) w_next = ST_IDLE;
  end

  assign w_state_change = (w_next != r_state);
  assign w_cnt_en       = (r_state == ST_SHIFT_IN) || (r_state == ST_SHIFT_OUT);

  scan_bit_counter #(
    .CHAIN_LEN (CHAIN_LEN),
    .CNT_W     (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .r        (r),
    .i_clear  (w_state_change),
    .i_enable (w_cnt_en),
    .o_count  (w_count),
    .o_tc     (w_tc)
  );

  // Response word with the bit currently on scan_out merged in at its position.
  always_comb begin
    w_captured          = r_shift_out;
    w_captured[w_count] = scan_out;
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (r) begin
      r_state     <= ST_IDLE;
      r_pattern   <= '0;
      r_shift_out <= '0;
      r_result    <= '0;
      r_scan_en   <= 1'b0;
      r_scan_in   <= 1'b0;
      r_capture   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_scan_en <= (w_next == ST_SHIFT_IN) || (w_next == ST_SHIFT_OUT);
      r_capture <= (w_next == ST_CAPTURE);
      r_busy    <= (w_next != ST_IDLE);
      r_done    <= (w_next == ST_DONE);
      r_scan_in <= 1'b0;

      if (r_state == ST_IDLE && w_next == ST_SHIFT_IN) begin
        r_pattern <= pattern;
        r_scan_in <= pattern[0];
      end else if (r_state == ST_SHIFT_IN && w_next == ST_SHIFT_IN) begin
        r_scan_in <= r_pattern[w_count + CNT_W'(1)];
      end

      if (r_state == ST_SHIFT_OUT) begin
        r_shift_out <= w_captured;
      end
      // Commit only on a completed run so an abort leaves result untouched.
      if (w_next == ST_DONE) begin
        r_result <= w_captured;
      end
    end
  end

  assign scan_en = r_scan_en;
  assign scan_in = r_scan_in;
  assign capture = r_capture;
  assign busy    = r_busy;
  assign done    = r_done;
  assign result  = r_result;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: an 8-stage dff_cell chain model plus a
// cycle-indexed expectation model of the controller's sequence.
module tb_scan_chain_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         r;
  logic         start;
  logic         abort;
  logic [N-1:0] pattern;
  logic         scan_out;
  logic         scan_en;
  logic         scan_in;
  logic         capture;
  logic         busy;
  logic         done;
  logic [N-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  scan_chain_ctrl #(.CHAIN_LEN(N)) dut (
    .clk      (clk),
    .r        (r),
    .start    (start),
    .abort    (abort),
    .pattern  (pattern),
    .scan_out (scan_out),
    .scan_en  (scan_en),
    .scan_in  (scan_in),
    .capture  (capture),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  // Chain of dff_cells: stage 0 fed by scan_in, stage N-1 drives scan_out.
  logic [N-1:0] chain = '0;
  bit           inv_capture = 1'b0;

  always @(posedge clk) begin
    if (scan_en)      chain <= {chain[N-2:0], scan_in};
    else if (capture) chain <= inv_capture ? ~chain : chain;
  end

  assign scan_out = chain[N-1];

  typedef struct packed {
    logic scan_en;
    logic scan_in;
    logic capture;
    logic busy;
    logic done;
  } outs_t;

  // Expected outputs in cycle k of an uninterrupted run started at edge 0.
  function automatic outs_t expect_outs(input int k, input logic [N-1:0] pat);
    outs_t o;
    o = '0;
    if (k >= 1 && k <= N) begin
      o.scan_en = 1'b1;
      o.scan_in = pat[k-1];
      o.busy    = 1'b1;
    end else if (k == N + 1) begin
      o.capture = 1'b1;
      o.busy    = 1'b1;
    end else if (k >= N + 2 && k <= 2 * N + 1) begin
      o.scan_en = 1'b1;
      o.busy    = 1'b1;
    end else if (k == 2 * N + 2) begin
      o.done    = 1'b1;
      o.busy    = 1'b1;
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [N-1:0] exp_res);
    check({tag, ".scan_en"}, 32'(scan_en), 32'd0);
    check({tag, ".scan_in"}, 32'(scan_in), 32'd0);
    check({tag, ".capture"}, 32'(capture), 32'd0);
    check({tag, ".busy"},    32'(busy),    32'd0);
    check({tag, ".done"},    32'(done),    32'd0);
    check({tag, ".result"},  32'(result),  32'(exp_res));
  endtask

  logic [N-1:0] prior_result = '0;

  // One start with optional extra starts, abort cycle or reset cycle (0 = none).
  task automatic run_seq(input logic [N-1:0] pat, input bit inv, input int abort_cyc,
                         input int rst_cyc, input bit extra_starts, input string name);
    int           stop_cyc;
    int           n_done;
    outs_t        e;
    logic [N-1:0] exp_res;
    logic [N-1:0] final_res;
    string        t;

    inv_capture = inv;
    final_res   = inv ? ~pat : pat;
    stop_cyc    = (abort_cyc > 0) ? abort_cyc : rst_cyc;
    n_done      = 0;

    start   = 1'b1;
    abort   = 1'b0;
    pattern = pat;
    step();
    start   = 1'b0;

    for (int k = 1; k <= 2 * N + 4; k++) begin
      pattern = N'($urandom);
      if (stop_cyc > 0 && k > stop_cyc) e = '0;
      else                              e = expect_outs(k, pat);

      if (rst_cyc > 0 && k > rst_cyc)              exp_res = '0;
      else if (stop_cyc == 0 && k >= 2 * N + 2)    exp_res = final_res;
      else                                         exp_res = prior_result;

      t = $sformatf("%s.c%0d", name, k);
      check({t, ".scan_en"}, 32'(scan_en), 32'(e.scan_en));
      check({t, ".scan_in"}, 32'(scan_in), 32'(e.scan_in));
      check({t, ".capture"}, 32'(capture), 32'(e.capture));
      check({t, ".busy"},    32'(busy),    32'(e.busy));
      check({t, ".done"},    32'(done),    32'(e.done));
      check({t, ".excl"},    32'(capture & scan_en), 32'd0);
      if (k <= N + 1 || k >= 2 * N + 2 || (stop_cyc > 0 && k > stop_cyc))
        check({t, ".result"}, 32'(result), 32'(exp_res));
      if (done === 1'b1) n_done++;

      start = extra_starts && (k == 3 || k == 2 * N + 2);
      abort = (k == abort_cyc);
      r     = (k == rst_cyc);
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    r     = 1'b0;

    check({name, ".n_done"}, 32'(n_done), (stop_cyc == 0) ? 32'd1 : 32'd0);
    if (rst_cyc > 0)        prior_result = '0;
    else if (stop_cyc == 0) prior_result = final_res;
  endtask

  initial begin
    r       = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = '0;
    step();
    step();
    check_idle("reset", '0);
    r = 1'b0;
    step();
    check_idle("post_reset", '0);

    run_seq(8'hA5, 1'b0, 0, 0, 1'b0, "a5_noninv");
    run_seq(8'hA5, 1'b1, 0, 0, 1'b0, "a5_inv");
    run_seq(N'($urandom), 1'b0, 0, 0, 1'b1, "extra_start");
    run_seq(N'($urandom), 1'b1, 12, 0, 1'b0, "abort_c12");
    run_seq(N'($urandom), 1'b0, 0, 0, 1'b0, "after_abort");
    run_seq(N'($urandom), 1'b1, 0, 5, 1'b0, "reset_c5");

    // start and abort together in IDLE must not launch a run
    start   = 1'b1;
    abort   = 1'b1;
    pattern = N'($urandom);
    step();
    start   = 1'b0;
    abort   = 1'b0;
    check_idle("start_abort", prior_result);
    step();
    check_idle("start_abort_2", prior_result);

    for (int i = 0; i < 4; i++)
      run_seq(N'($urandom), 1'($urandom), 0, 0, 1'b0, $sformatf("rand%0d", i));
    for (int i = 0; i < 3; i++)
      run_seq(N'($urandom), 1'($urandom), $urandom_range(1, 2 * N + 1), 0, 1'b0,
              $sformatf("rand_abort%0d", i));
    run_seq(N'($urandom), 1'b0, 0, 0, 1'b0, "final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
